// File: rtl/alu_pkg.sv
// Shared definitions for the alu_exec execute stage: opcodes, FSM states and
// the single-cycle result/flag helper. ALU_MUL_EN adds the MUL state/mode.
package alu_pkg;

    localparam int ALU_DW = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
    typedef enum logic [1:0] {SEQ_SHL, SEQ_SHR, SEQ_SAR, SEQ_MUL} seq_mode_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
    typedef enum logic [1:0] {SEQ_SHL, SEQ_SHR, SEQ_SAR} seq_mode_t;
`endif

    typedef struct packed {
        logic [ALU_DW-1:0] res;
        logic              zf;
        logic              nf;
        logic              cf;
        logic              of;
        logic              wr;
        logic              legal;
    } alu_out_t;

    // Shift opcodes land here only with a zero count, where they act as a move of A.
    function automatic alu_out_t alu_single(input logic [3:0]        op,
                                            input logic [ALU_DW-1:0] a,
                                            input logic [ALU_DW-1:0] b);
        alu_out_t        o;
        logic [ALU_DW:0] sum;
        o       = '0;
        o.wr    = 1'b1;
        o.legal = 1'b1;
        sum     = '0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                o.res = sum[ALU_DW-1:0];
                o.cf  = sum[ALU_DW];
                o.of  = (a[ALU_DW-1] == b[ALU_DW-1]) && (o.res[ALU_DW-1] != a[ALU_DW-1]);
            end
            OP_SUB, OP_CMP: begin
                sum   = {1'b0, a} - {1'b0, b};
                o.res = sum[ALU_DW-1:0];
                o.cf  = sum[ALU_DW];
                o.of  = (a[ALU_DW-1] != b[ALU_DW-1]) && (o.res[ALU_DW-1] != a[ALU_DW-1]);
                o.wr  = (op != OP_CMP);
            end
            OP_AND:                 o.res = a & b;
            OP_OR:                  o.res = a | b;
            OP_XOR:                 o.res = a ^ b;
            OP_NOT:                 o.res = ~a;
            OP_MOV:                 o.res = b;
            OP_SHL, OP_SHR, OP_SAR: o.res = a;
            default: begin
                o.wr    = 1'b0;
                o.legal = 1'b0;
            end
        endcase
        o.zf = (o.res == '0);
        o.nf = o.res[ALU_DW-1];
        return o;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand/write-back bundle between operand-select and the alu_exec stage.
interface alu_exec_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          en_in;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] result;
    logic [RW-1:0] wb_addr;
    logic          wb_en;
    logic          en_out;
    logic          busy;
    logic          illegal;
    logic          zf;
    logic          nf;
    logic          cf;
    logic          of;

    modport master (
        output en_in, alu_a, alu_b, alu_op, rd_addr,
        input  result, wb_addr, wb_en, en_out, busy, illegal, zf, nf, cf, of
    );

    modport slave (
        input  en_in, alu_a, alu_b, alu_op, rd_addr,
        output result, wb_addr, wb_en, en_out, busy, illegal, zf, nf, cf, of
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Iterative datapath for shifts (one bit per step) and, with ALU_MUL_EN,
// the 16-step unsigned shift-add multiplier. Outputs are next-step values.
module alu_seq_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  seq_mode_t         mode,
    input  logic [ALU_DW-1:0] ld_val,
    input  logic [4:0]        ld_cnt,
`ifdef ALU_MUL_EN
    input  logic [ALU_DW-1:0] mcand_in,
`endif
    output logic              last,
    output logic [ALU_DW-1:0] res,
    output logic              cf,
    output logic              of
);
    seq_mode_t           mode_q;
    logic [4:0]          cnt;
    logic [2*ALU_DW-1:0] acc;
    logic [2*ALU_DW-1:0] acc_nxt;
`ifdef ALU_MUL_EN
    logic [ALU_DW-1:0]   mcand;
    logic [ALU_DW:0]     psum;
`endif

    always_comb begin
        acc_nxt = acc;
        cf      = 1'b0;
        of      = 1'b0;
`ifdef ALU_MUL_EN
        psum    = '0;
`endif
        case (mode_q)
            SEQ_SHL: begin
                acc_nxt[ALU_DW-1:0] = {acc[ALU_DW-2:0], 1'b0};
                cf                  = acc[ALU_DW-1];
            end
            SEQ_SHR: begin
                acc_nxt[ALU_DW-1:0] = {1'b0, acc[ALU_DW-1:1]};
                cf                  = acc[0];
            end
            SEQ_SAR: begin
                acc_nxt[ALU_DW-1:0] = {acc[ALU_DW-1], acc[ALU_DW-1:1]};
                cf                  = acc[0];
            end
`ifdef ALU_MUL_EN
            // Upper half accumulates, lower half holds the remaining multiplier bits.
            SEQ_MUL: begin
                psum    = {1'b0, acc[2*ALU_DW-1:ALU_DW]} + (acc[0] ? {1'b0, mcand} : '0);
                acc_nxt = {psum, acc[ALU_DW-1:1]};
                of      = (acc_nxt[2*ALU_DW-1:ALU_DW] != '0);
                cf      = of;
            end
`endif
            default: ;
        endcase
    end

    assign res  = acc_nxt[ALU_DW-1:0];
    assign last = (cnt == 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= SEQ_SHL;
            cnt    <= '0;
            acc    <= '0;
`ifdef ALU_MUL_EN
            mcand  <= '0;
`endif
        end else if (load) begin
            mode_q <= mode;
            cnt    <= ld_cnt;
            acc    <= {{ALU_DW{1'b0}}, ld_val};
`ifdef ALU_MUL_EN
            mcand  <= mcand_in;
`endif
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt - 5'd1;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// tinylabcpu execute stage: operand capture, FSM, result/flag registers and
// write-back strobe. Define ALU_MUL_EN to enable opcode 11 (shift-add multiply).
module alu_exec
    import alu_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input logic       clk,
    input logic       rst,
    alu_exec_if.slave bus
);
    state_t        state, state_nxt;
    alu_out_t      sc;
    seq_mode_t     seq_mode;
    logic          is_shift, seq_load, seq_step, seq_last;
    logic          single_fire, seq_fire, seq_cf, seq_of;
    logic [DW-1:0] seq_res, seq_ld_val;
    logic [4:0]    seq_ld_cnt;
    logic [RW-1:0] rd_q, wb_addr_q;
    logic [DW-1:0] result_q;
    logic          en_out_q, wb_en_q, illegal_q, zf_q, nf_q, cf_q, of_q;

    assign sc       = alu_single(bus.alu_op, bus.alu_a, bus.alu_b);
    assign is_shift = (bus.alu_op == OP_SHL) || (bus.alu_op == OP_SHR) || (bus.alu_op == OP_SAR);

    always_comb begin
        seq_mode   = SEQ_SHL;
        seq_ld_val = bus.alu_a;
        seq_ld_cnt = {1'b0, bus.alu_b[3:0]};
        case (bus.alu_op)
            OP_SHR: seq_mode = SEQ_SHR;
            OP_SAR: seq_mode = SEQ_SAR;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                seq_mode   = SEQ_MUL;
                seq_ld_val = bus.alu_b;
                seq_ld_cnt = 5'd16;
            end
`endif
            default: ;
        endcase
    end

    alu_seq_unit u_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (seq_load),
        .step     (seq_step),
        .mode     (seq_mode),
        .ld_val   (seq_ld_val),
        .ld_cnt   (seq_ld_cnt),
`ifdef ALU_MUL_EN
        .mcand_in (bus.alu_a),
`endif
        .last     (seq_last),
        .res      (seq_res),
        .cf       (seq_cf),
        .of       (seq_of)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        seq_load    = 1'b0;
        seq_step    = 1'b0;
        single_fire = 1'b0;
        seq_fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.en_in) begin
                    if (is_shift && (bus.alu_b[3:0] != 4'd0)) begin
                        state_nxt = S_SHIFT;
                        seq_load  = 1'b1;
                    end
`ifdef ALU_MUL_EN
                    else if (bus.alu_op == OP_MUL) begin
                        state_nxt = S_MUL;
                        seq_load  = 1'b1;
                    end
`endif
                    else begin
                        single_fire = 1'b1;
                    end
                end
            end
`ifdef ALU_MUL_EN
            S_SHIFT, S_MUL: begin
`else
            S_SHIFT: begin
`endif
                seq_step = 1'b1;
                if (seq_last) begin
                    seq_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reserved opcodes and CMP complete without touching result; reserved also keeps flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q  <= '0;
            wb_addr_q <= '0;
            rd_q      <= '0;
            en_out_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            zf_q      <= 1'b0;
            nf_q      <= 1'b0;
            cf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            en_out_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (seq_load) rd_q <= bus.rd_addr;
            if (single_fire) begin
                en_out_q <= 1'b1;
                if (sc.legal) begin
                    zf_q <= sc.zf;
                    nf_q <= sc.nf;
                    cf_q <= sc.cf;
                    of_q <= sc.of;
                    if (sc.wr) begin
                        result_q  <= sc.res;
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= bus.rd_addr;
                    end
                end else begin
                    illegal_q <= 1'b1;
                end
            end
            if (seq_fire) begin
                en_out_q  <= 1'b1;
                wb_en_q   <= 1'b1;
                wb_addr_q <= rd_q;
                result_q  <= seq_res;
                zf_q      <= (seq_res == '0);
                nf_q      <= seq_res[DW-1];
                cf_q      <= seq_cf;
                of_q      <= seq_of;
            end
        end
    end

    assign bus.result  = result_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.en_out  = en_out_q;
    assign bus.illegal = illegal_q;
    assign bus.busy    = (state != S_IDLE);
    assign bus.zf      = zf_q;
    assign bus.nf      = nf_q;
    assign bus.cf      = cf_q;
    assign bus.of      = of_q;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized ops against
// an arithmetic reference model. Honours ALU_MUL_EN the same way as the RTL.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_if #(.DW(16), .RW(3)) bus ();
    alu_exec #(.DW(16), .RW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_res;
    logic        m_zf, m_nf, m_cf, m_of;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output bit wr, output bit ill);
        int          sa, sb, s, n;
        logic [31:0] p;
        logic [15:0] r;
        bit          c, o;
        sa = $signed(a);
        sb = $signed(b);
        n  = int'(b[3:0]);
        lat = 0; wr = 1; ill = 0; r = '0; c = 0; o = 0; p = '0; s = 0;
        case (op)
            4'd0: begin
                p = a + b; r = p[15:0]; c = p[16];
                s = sa + sb; o = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd7: begin
                r = a - b; c = (a < b);
                s = sa - sb; o = (s > 32767) || (s < -32768);
                wr = (op != 4'd7);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: r = b;
            4'd8: begin
                p = {16'h0, a} << n; r = p[15:0]; c = (n != 0) && p[16]; lat = n;
            end
            4'd9: begin
                r = a >> n; c = (n != 0) && a[n-1]; lat = n;
            end
            4'd10: begin
                s = sa >>> n; r = s[15:0]; c = (n != 0) && a[n-1]; lat = n;
            end
`ifdef ALU_MUL_EN
            4'd11: begin
                p = a * b; r = p[15:0]; c = (p[31:16] != 0); o = c; lat = 16;
            end
`endif
            default: begin ill = 1; wr = 0; end
        endcase
        if (!ill) begin
            m_zf = (r == 16'h0);
            m_nf = r[15];
            m_cf = c;
            m_of = o;
            if (wr) m_res = r;
        end
    endtask

    task automatic check_flags(input string pfx);
        check({pfx, "_result"}, bus.result, m_res);
        check({pfx, "_zf"}, bus.zf, m_zf);
        check({pfx, "_nf"}, bus.nf, m_nf);
        check({pfx, "_cf"}, bus.cf, m_cf);
        check({pfx, "_of"}, bus.of, m_of);
    endtask

    // Issue one op, wait (bounded) for completion, check latency/outputs and pulse width.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] rd, input bit poke);
        int lat, cyc;
        bit wr, ill;
        model(op, a, b, lat, wr, ill);
        bus.en_in = 1'b1; bus.alu_op = op; bus.alu_a = a; bus.alu_b = b; bus.rd_addr = rd;
        @(posedge clk); #1;
        bus.en_in = 1'b0;
        cyc = 0;
        while (bus.en_out !== 1'b1 && cyc < 40) begin
            check("busy_mid", bus.busy, 1);
            if (poke && cyc == 1) begin
                bus.en_in = 1'b1; bus.alu_op = OP_MOV; bus.alu_b = 16'h5A5A; bus.rd_addr = ~rd;
            end else begin
                bus.en_in = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.en_in = 1'b0;
        check("latency", cyc, lat);
        check("busy_done", bus.busy, 0);
        check("wb_en", bus.wb_en, wr);
        check("illegal", bus.illegal, ill);
        if (wr) check("wb_addr", bus.wb_addr, rd);
        check_flags("op");
        @(posedge clk); #1;
        check("pulse_width", {bus.en_out, bus.wb_en, bus.illegal}, 3'b000);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_result"}, bus.result, 0);
        check({pfx, "_wb_addr"}, bus.wb_addr, 0);
        check({pfx, "_strobes"}, {bus.en_out, bus.wb_en, bus.busy, bus.illegal}, 4'b0000);
        check({pfx, "_flags"}, {bus.zf, bus.nf, bus.cf, bus.of}, 4'b0000);
    endtask

    task automatic back_to_back();
        logic [3:0]  ops [3];
        logic [15:0] a, b;
        int lat; bit wr, ill;
        ops[0] = OP_ADD; ops[1] = OP_XOR; ops[2] = OP_MOV;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            model(ops[i], a, b, lat, wr, ill);
            bus.en_in = 1'b1; bus.alu_op = ops[i]; bus.alu_a = a; bus.alu_b = b;
            bus.rd_addr = 3'(i + 1);
            @(posedge clk); #1;
            check("b2b_en_out", bus.en_out, 1);
            check("b2b_wb_addr", bus.wb_addr, i + 1);
            check_flags("b2b");
        end
        bus.en_in = 1'b0;
        @(posedge clk); #1;
        check("b2b_end", bus.en_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        rst = 1'b0;
        bus.en_in = 1'b0; bus.alu_op = '0; bus.alu_a = '0; bus.alu_b = '0; bus.rd_addr = '0;
        m_res = '0; m_zf = 0; m_nf = 0; m_cf = 0; m_of = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(OP_ADD, 16'h7FFF, 16'h0001, 3'd5, 0);
        check("add_const", {bus.result, bus.of, bus.nf, bus.cf, bus.zf}, {16'h8000, 4'b1100});
        run_op(OP_SUB, 16'h0003, 16'h0005, 3'd2, 0);
        check("sub_const", {bus.result, bus.cf, bus.nf}, {16'hFFFE, 2'b11});
        run_op(OP_CMP, 16'h1234, 16'h1234, 3'd3, 0);
        check("cmp_const", {bus.result, bus.zf}, {16'hFFFE, 1'b1});
        run_op(OP_SAR, 16'h8001, 16'h0004, 3'd4, 1);
        check("sar_const", {bus.result, bus.cf}, {16'hF800, 1'b0});
        run_op(OP_SHL, 16'hBEEF, 16'h0000, 3'd6, 0);
        check("shl0_const", {bus.result, bus.cf}, {16'hBEEF, 1'b0});
        run_op(OP_SHL, 16'h8001, 16'h000F, 3'd1, 0);
        run_op(OP_MUL, 16'h0100, 16'h0100, 3'd7, 1);
`ifdef ALU_MUL_EN
        check("mul_const", {bus.result, bus.zf, bus.cf}, {16'h0000, 2'b11});
`endif
        run_op(4'd13, 16'h0000, 16'h0000, 3'd2, 0);
        back_to_back();

        // Reset in the middle of a long multi-cycle op.
`ifdef ALU_MUL_EN
        op = OP_MUL; b = 16'h00FF;
`else
        op = OP_SHR; b = 16'h000F;
`endif
        bus.en_in = 1'b1; bus.alu_op = op; bus.alu_a = 16'h1234; bus.alu_b = b; bus.rd_addr = 3'd3;
        @(posedge clk); #1;
        bus.en_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check_all_zero("midop_reset");
        m_res = '0; m_zf = 0; m_nf = 0; m_cf = 0; m_of = 0;
        #2 rst = 1'b1;
        run_op(OP_ADD, 16'h0102, 16'h0304, 3'd5, 0);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 5))
                0: a = 16'h7FFF;
                1: a = 16'h8000;
                2: b = 16'hFFFF;
                default: ;
            endcase
            run_op(op, a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage of the tinylabcpu datapath. Sits directly downstream of the ALU operand-select stage.
- Consumes the registered operand pair alu_a/alu_b and its enable pulse. Performs the operation, registers the result and the status flags, and issues the register-file write-back request.
- Single-cycle ops complete in one clock. Shifts and multiply iterate under a small FSM and raise busy to stall issue.

Parameters:
- DW, 16, datapath width. Only 16 is supported; it is exposed for readability.
- RW, 3, width of the destination register address.

Ports:
- clk      in   1      system clock, rising edge.
- rst      in   1      asynchronous, active-low reset.
- en_in    in   1      operand-valid pulse from the operand-select stage.
- alu_a    in   16     operand A (Rd value).
- alu_b    in   16     operand B (Rs value or zero-extended offset).
- alu_op   in   4      opcode, sampled with en_in.
- rd_addr  in   RW     destination register, sampled with en_in.
- result   out  16     registered result.
- wb_addr  out  RW     registered destination.
- wb_en    out  1      one-cycle write-back strobe.
- en_out   out  1      one-cycle completion pulse (every accepted op, including CMP and reserved).
- busy     out  1      multi-cycle op in flight.
- illegal  out  1      one-cycle pulse for a reserved opcode.
- zf, nf, cf, of  out  1 each  registered status flags.

Behaviour:
- Reset: state=IDLE. result, wb_addr, wb_en, en_out, busy, illegal and all flags = 0. Asserting reset mid-operation aborts the op with no completion pulse.
- Accept: en_in=1 while state=IDLE captures alu_a, alu_b, alu_op and rd_addr. en_in while busy=1 is dropped silently; upstream must not issue while busy.
- Opcodes and single-cycle latency. result/en_out are valid on the edge after accept.
  - 0 ADD: a+b. cf=carry out; of=signed overflow.
  - 1 SUB: a-b. cf=borrow (a<b unsigned); of=signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT (~a), 6 MOV (b). cf=of=0.
  - 7 CMP: same flags as SUB. wb_en=0 and result is unchanged.
- Shifts (FSM state SHIFT). Count n=b[3:0].
  - 8 SHL, 9 SHR (logical), 10 SAR (arithmetic). One bit per cycle.
  - busy=1 from the cycle after accept until completion.
  - en_out/wb_en pulse n cycles after accept (n≥1). n=0 behaves as single-cycle: result=a, cf=0.
  - cf = last bit shifted out; of=0.
- MUL, 11 (FSM state MUL): 16-iteration shift-add, unsigned.
  - busy for 16 cycles; en_out on the 16th edge after accept.
  - result = product[15:0]; cf = of = (product[31:16]!=0).
- Reserved 12–15: en_out=1 and illegal=1 for one cycle. wb_en=0; result and all flags are unchanged.
- zf = (result==0) and nf = result[15] for every op except reserved. CMP derives zf/nf from the difference.
- FSM transitions:
  - IDLE→SHIFT on accept of 8–10 with n≠0.
  - IDLE→MUL on accept of 11.
  - SHIFT→IDLE when the remaining count reaches 0.
  - MUL→IDLE after iteration 16.
  - busy deasserts on the same edge that en_out asserts, so a new en_in is accepted in the next cycle.
- Back-to-back single-cycle ops accept every cycle with no bubble.
- en_out, wb_en and illegal are single-cycle pulses, never held.
- Arithmetic wraps modulo 2^16. Flags hold their value between ops.

Optional Feature:
- ALU_MUL_EN defined: opcode 11 is the shift-add multiplier described above.
- ALU_MUL_EN undefined: no multiplier logic and no MUL state. Opcode 11 is treated as reserved (illegal pulse, no write-back).

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - FSM state encoding S_IDLE/S_SHIFT/S_MUL;
  - the DW constant;
  - a helper function that computes the single-cycle result and flags.
- One sub-module is natural: alu_seq_unit (iterative shift/multiply datapath plus counter). alu_exec holds the FSM, operand capture and output registers.

Test Plan:
- ADD a=0x7FFF b=0x0001 → result=0x8000, of=1, nf=1, cf=0, zf=0, wb_en pulse with wb_addr as issued, one cycle after en_in.
- SUB a=0x0003 b=0x0005 → result=0xFFFE, cf=1, nf=1; then CMP a=0x1234 b=0x1234 → zf=1, wb_en=0, result still 0xFFFE.
- SAR a=0x8001 b=0x0004 → busy high 4 cycles, result=0xF800, cf=0; en_in pulsed mid-op is ignored; SHL b=0 → single-cycle, result=a.
- MUL a=0x0100 b=0x0100 (ALU_MUL_EN) → en_out after 16 cycles, result=0x0000, zf=1, cf=1; build without macro → illegal pulse, no wb_en.
- Opcode 13 → en_out=1, illegal=1, wb_en=0, flags unchanged; back-to-back ADD/XOR/MOV on consecutive cycles → three consecutive en_out pulses.
- rst low during MUL cycle 7 → all outputs 0 immediately; after release an ADD completes normally.
